// File: rtl/display_mode_ctrl_if.sv
// Button/timing inputs and display outputs of the bicycle computer's display-mode controller.
// The master modport drives the button and timing pulses; the slave is the controller.
interface display_mode_ctrl_if;
  logic       mode;
  logic       sec_pulse;
  logic       half_sec_pulse;
  logic [1:0] mode_sel;
  logic       DAY;
  logic       AVS;
  logic       TIM;
  logic       MAX;
  logic       col;
  logic       point;
  logic       clr_day;
  logic       clr_max;

  modport master (
    output mode, sec_pulse, half_sec_pulse,
    input  mode_sel, DAY, AVS, TIM, MAX, col, point, clr_day, clr_max
  );

  modport slave (
    input  mode, sec_pulse, half_sec_pulse,
    output mode_sel, DAY, AVS, TIM, MAX, col, point, clr_day, clr_max
  );
endinterface

// File: rtl/display_mode_ctrl.sv
// Debounces the mode button and cycles the display DAY -> AVS -> TIM -> MAX.
// Define DISPLAY_LONG_PRESS_CLEAR_EN to make a long hold clear distance (DAY) or max speed (MAX).
module display_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_PRESS_SEC  = 2
) (
  input logic                clock,
  input logic                reset,
  display_mode_ctrl_if.slave bus
);

  localparam int            CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_DAY = 2'd0,
    MODE_AVS = 2'd1,
    MODE_TIM = 2'd2,
    MODE_MAX = 2'd3
  } mode_e;

`ifdef DISPLAY_LONG_PRESS_CLEAR_EN
  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG} state_e;
  localparam logic [2:0] HoldLast = 3'(LONG_PRESS_SEC);
  logic [2:0] holdCnt_q;
  logic       clrDay_q;
  logic       clrMax_q;
`else
  typedef enum logic {ST_IDLE, ST_HELD} state_e;
  localparam int unusedLongPressSec = LONG_PRESS_SEC;
  logic unusedSecPulse;
  assign unusedSecPulse = bus.sec_pulse;
`endif

  logic            sync1_q;
  logic            sync2_q;
  logic [CntW-1:0] dbCnt_q;
  logic            btn_q;
  state_e          state_q;
  mode_e           mode_q;
  logic [3:0]      ind_q;
  logic            col_q;
  logic            point_q;
  mode_e           modeNext_d;
  logic [3:0]      indNext_d;

  // The debounced level only flips after the synchronized sample has disagreed for a full run.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dbCnt_q <= '0;
      btn_q   <= 1'b0;
    end else begin
      sync1_q <= bus.mode;
      sync2_q <= sync1_q;
      if (sync2_q == btn_q) begin
        dbCnt_q <= '0;
      end else if (dbCnt_q == CntLast) begin
        dbCnt_q <= '0;
        btn_q   <= sync2_q;
      end else begin
        dbCnt_q <= dbCnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    modeNext_d = mode_e'(mode_q + 2'd1);
    indNext_d  = 4'b1000 >> modeNext_d;
  end

  // Button FSM and registered display outputs. The short action's col assignment comes last,
  // so a half-second pulse in the cycle TIM is entered is overridden by the entry value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_DAY;
      ind_q     <= 4'b1000;
      col_q     <= 1'b0;
      point_q   <= 1'b1;
`ifdef DISPLAY_LONG_PRESS_CLEAR_EN
      holdCnt_q <= '0;
      clrDay_q  <= 1'b0;
      clrMax_q  <= 1'b0;
`endif
    end else begin
`ifdef DISPLAY_LONG_PRESS_CLEAR_EN
      clrDay_q <= 1'b0;
      clrMax_q <= 1'b0;
`endif
      if (mode_q == MODE_TIM && bus.half_sec_pulse) begin
        col_q <= ~col_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (btn_q) begin
            state_q   <= ST_HELD;
`ifdef DISPLAY_LONG_PRESS_CLEAR_EN
            holdCnt_q <= '0;
`endif
          end
        end
        ST_HELD: begin
          if (!btn_q) begin
            state_q <= ST_IDLE;
            mode_q  <= modeNext_d;
            ind_q   <= indNext_d;
            point_q <= (modeNext_d != MODE_TIM);
            col_q   <= (modeNext_d == MODE_TIM);
          end
`ifdef DISPLAY_LONG_PRESS_CLEAR_EN
          else if (bus.sec_pulse) begin
            holdCnt_q <= holdCnt_q + 3'd1;
            if (holdCnt_q + 3'd1 == HoldLast) begin
              state_q  <= ST_LONG;
              clrDay_q <= (mode_q == MODE_DAY);
              clrMax_q <= (mode_q == MODE_MAX);
            end
          end
`endif
        end
`ifdef DISPLAY_LONG_PRESS_CLEAR_EN
        ST_LONG: begin
          if (!btn_q) begin
            state_q <= ST_IDLE;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mode_sel = mode_q;
  assign bus.DAY      = ind_q[3];
  assign bus.AVS      = ind_q[2];
  assign bus.TIM      = ind_q[1];
  assign bus.MAX      = ind_q[0];
  assign bus.col      = col_q;
  assign bus.point    = point_q;
`ifdef DISPLAY_LONG_PRESS_CLEAR_EN
  assign bus.clr_day  = clrDay_q;
  assign bus.clr_max  = clrMax_q;
`else
  assign bus.clr_day  = 1'b0;
  assign bus.clr_max  = 1'b0;
`endif

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Directed bench for display_mode_ctrl; long-press expectations follow DISPLAY_LONG_PRESS_CLEAR_EN.
module tb_display_mode_ctrl;

  logic clock;
  logic reset;
  int   checkCount = 0;
  int   passCount  = 0;
  int   clrDayCount = 0;
  int   clrMaxCount = 0;
  logic [1:0] expMode;

  display_mode_ctrl_if bus ();

  display_mode_ctrl #(
    .DEBOUNCE_CYCLES(16),
    .LONG_PRESS_SEC (2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus.clr_day) clrDayCount <= clrDayCount + 1;
    if (bus.clr_max) clrMaxCount <= clrMaxCount + 1;
  end

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pressRelease();
    bus.mode = 1'b1;
    cycle(40);
    bus.mode = 1'b0;
    cycle(40);
  endtask

  task automatic test_reset();
    cycle(3);
    checkCount++;
    if (bus.mode_sel !== 2'd0) $display("[TB] FAIL reset_mode_sel: got %0d want 0", bus.mode_sel);
    else passCount++;
    checkCount++;
    if ({bus.DAY, bus.AVS, bus.TIM, bus.MAX} !== 4'b1000)
      $display("[TB] FAIL reset_ind: got %b want 1000", {bus.DAY, bus.AVS, bus.TIM, bus.MAX});
    else passCount++;
    checkCount++;
    if ({bus.col, bus.point, bus.clr_day, bus.clr_max} !== 4'b0100)
      $display("[TB] FAIL reset_misc: got %b want 0100", {bus.col, bus.point, bus.clr_day, bus.clr_max});
    else passCount++;
    reset = 1'b1;
    cycle(2);
  endtask

  task automatic test_short_press();
    logic [1:0] wantSel   [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] wantInd   [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    logic       wantPoint [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic       wantCol   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      pressRelease();
      checkCount++;
      if (bus.mode_sel !== wantSel[i])
        $display("[TB] FAIL short_mode_sel[%0d]: got %0d want %0d", i, bus.mode_sel, wantSel[i]);
      else passCount++;
      checkCount++;
      if ({bus.DAY, bus.AVS, bus.TIM, bus.MAX} !== wantInd[i])
        $display("[TB] FAIL short_ind[%0d]: got %b want %b", i, {bus.DAY, bus.AVS, bus.TIM, bus.MAX}, wantInd[i]);
      else passCount++;
      checkCount++;
      if (bus.point !== wantPoint[i])
        $display("[TB] FAIL short_point[%0d]: got %b want %b", i, bus.point, wantPoint[i]);
      else passCount++;
      checkCount++;
      if (bus.col !== wantCol[i])
        $display("[TB] FAIL short_col[%0d]: got %b want %b", i, bus.col, wantCol[i]);
      else passCount++;
    end
    expMode = 2'd0;
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 5; i++) begin
      bus.mode = 1'b1;
      cycle(3);
      bus.mode = 1'b0;
      cycle(3);
    end
    cycle(20);
    checkCount++;
    if (bus.mode_sel !== 2'd0) $display("[TB] FAIL bounce_ignored: got %0d want 0", bus.mode_sel);
    else passCount++;
    bus.mode = 1'b1;
    cycle(40);
    bus.mode = 1'b0;
    cycle(18);
    checkCount++;
    if (bus.mode_sel !== 2'd0) $display("[TB] FAIL bounce_early: got %0d want 0", bus.mode_sel);
    else passCount++;
    cycle(1);
    checkCount++;
    if (bus.mode_sel !== 2'd1) $display("[TB] FAIL bounce_latency: got %0d want 1", bus.mode_sel);
    else passCount++;
    cycle(40);
    checkCount++;
    if (bus.mode_sel !== 2'd1) $display("[TB] FAIL bounce_single: got %0d want 1", bus.mode_sel);
    else passCount++;
    expMode = 2'd1;
  endtask

  task automatic test_colon();
    logic wantCol [3] = '{1'b0, 1'b1, 1'b0};
    pressRelease();
    checkCount++;
    if ({bus.mode_sel, bus.col} !== 3'b10_1)
      $display("[TB] FAIL col_entry: got sel=%0d col=%b want sel=2 col=1", bus.mode_sel, bus.col);
    else passCount++;
    for (int i = 0; i < 3; i++) begin
      bus.half_sec_pulse = 1'b1;
      cycle(1);
      bus.half_sec_pulse = 1'b0;
      checkCount++;
      if (bus.col !== wantCol[i]) $display("[TB] FAIL col_toggle[%0d]: got %b want %b", i, bus.col, wantCol[i]);
      else passCount++;
      cycle(3);
    end
    pressRelease();
    checkCount++;
    if ({bus.mode_sel, bus.col, bus.point} !== 4'b11_0_1)
      $display("[TB] FAIL col_leave: got sel=%0d col=%b point=%b want sel=3 col=0 point=1", bus.mode_sel, bus.col, bus.point);
    else passCount++;
    expMode = 2'd3;
  endtask

  task automatic test_long_max();
    logic wantClr;
    logic [1:0] wantSel;
`ifdef DISPLAY_LONG_PRESS_CLEAR_EN
    wantClr = 1'b1;
    wantSel = 2'd3;
`else
    wantClr = 1'b0;
    wantSel = 2'd0;
`endif
    bus.mode = 1'b1;
    cycle(40);
    bus.sec_pulse = 1'b1;
    cycle(1);
    bus.sec_pulse = 1'b0;
    cycle(5);
    bus.sec_pulse = 1'b1;
    cycle(1);
    bus.sec_pulse = 1'b0;
    checkCount++;
    if ({bus.clr_max, bus.clr_day} !== {wantClr, 1'b0})
      $display("[TB] FAIL long_max_clr: got clr_max=%b clr_day=%b want %b 0", bus.clr_max, bus.clr_day, wantClr);
    else passCount++;
    cycle(1);
    checkCount++;
    if (bus.clr_max !== 1'b0) $display("[TB] FAIL long_max_clr_width: got %b want 0", bus.clr_max);
    else passCount++;
    bus.mode = 1'b0;
    cycle(40);
    checkCount++;
    if (bus.mode_sel !== wantSel) $display("[TB] FAIL long_max_mode: got %0d want %0d", bus.mode_sel, wantSel);
    else passCount++;
    checkCount++;
    if (clrMaxCount !== int'(wantClr)) $display("[TB] FAIL long_max_count: got %0d want %0d", clrMaxCount, wantClr);
    else passCount++;
    expMode = wantSel;
  endtask

  task automatic test_long_day();
    logic wantClr;
    logic [1:0] wantSel;
`ifdef DISPLAY_LONG_PRESS_CLEAR_EN
    pressRelease();
    wantClr = 1'b1;
    wantSel = 2'd0;
`else
    wantClr = 1'b0;
    wantSel = 2'd1;
`endif
    checkCount++;
    if (bus.mode_sel !== 2'd0) $display("[TB] FAIL long_day_start: got %0d want 0", bus.mode_sel);
    else passCount++;
    bus.mode = 1'b1;
    cycle(40);
    bus.sec_pulse = 1'b1;
    cycle(1);
    bus.sec_pulse = 1'b0;
    cycle(5);
    bus.sec_pulse = 1'b1;
    cycle(1);
    bus.sec_pulse = 1'b0;
    checkCount++;
    if ({bus.clr_day, bus.clr_max} !== {wantClr, 1'b0})
      $display("[TB] FAIL long_day_clr: got clr_day=%b clr_max=%b want %b 0", bus.clr_day, bus.clr_max, wantClr);
    else passCount++;
    cycle(1);
    checkCount++;
    if (bus.clr_day !== 1'b0) $display("[TB] FAIL long_day_clr_width: got %b want 0", bus.clr_day);
    else passCount++;
    bus.mode = 1'b0;
    cycle(40);
    checkCount++;
    if (bus.mode_sel !== wantSel) $display("[TB] FAIL long_day_mode: got %0d want %0d", bus.mode_sel, wantSel);
    else passCount++;
    checkCount++;
    if (clrDayCount !== int'(wantClr)) $display("[TB] FAIL long_day_count: got %0d want %0d", clrDayCount, wantClr);
    else passCount++;
    expMode = wantSel;
  endtask

  task automatic test_release_coincident();
    int dayBefore;
    int maxBefore;
    logic [1:0] wantSel;
    dayBefore = clrDayCount;
    maxBefore = clrMaxCount;
    wantSel = expMode + 2'd1;
    bus.mode = 1'b1;
    cycle(40);
    bus.sec_pulse = 1'b1;
    cycle(1);
    bus.sec_pulse = 1'b0;
    cycle(5);
    bus.mode = 1'b0;
    cycle(18);
    bus.sec_pulse = 1'b1;
    cycle(1);
    bus.sec_pulse = 1'b0;
    checkCount++;
    if (bus.mode_sel !== wantSel) $display("[TB] FAIL coincident_mode: got %0d want %0d", bus.mode_sel, wantSel);
    else passCount++;
    cycle(3);
    checkCount++;
    if (clrDayCount + clrMaxCount !== dayBefore + maxBefore)
      $display("[TB] FAIL coincident_no_clear: got %0d clears want %0d", clrDayCount + clrMaxCount, dayBefore + maxBefore);
    else passCount++;
    expMode = wantSel;
  endtask

  task automatic test_reset_mid_press();
    for (int i = 0; i < 4 && expMode != 2'd3; i++) begin
      pressRelease();
      expMode = expMode + 2'd1;
    end
    checkCount++;
    if (bus.mode_sel !== 2'd3) $display("[TB] FAIL midreset_start: got %0d want 3", bus.mode_sel);
    else passCount++;
    bus.mode = 1'b1;
    cycle(40);
    reset = 1'b0;
    #1;
    checkCount++;
    if ({bus.mode_sel, bus.DAY, bus.AVS, bus.TIM, bus.MAX, bus.col, bus.point, bus.clr_day, bus.clr_max} !== 10'b00_1000_0100)
      $display("[TB] FAIL midreset_async: got sel=%0d ind=%b col=%b point=%b want sel=0 ind=1000 col=0 point=1",
               bus.mode_sel, {bus.DAY, bus.AVS, bus.TIM, bus.MAX}, bus.col, bus.point);
    else passCount++;
    cycle(3);
    reset = 1'b1;
    cycle(40);
    checkCount++;
    if (bus.mode_sel !== 2'd0) $display("[TB] FAIL midreset_held: got %0d want 0", bus.mode_sel);
    else passCount++;
    bus.mode = 1'b0;
    cycle(19);
    checkCount++;
    if ({bus.mode_sel, bus.DAY, bus.AVS, bus.TIM, bus.MAX} !== 6'b01_0100)
      $display("[TB] FAIL midreset_release: got sel=%0d ind=%b want sel=1 ind=0100",
               bus.mode_sel, {bus.DAY, bus.AVS, bus.TIM, bus.MAX});
    else passCount++;
  endtask

  initial begin
    reset = 1'b0;
    bus.mode = 1'b0;
    bus.sec_pulse = 1'b0;
    bus.half_sec_pulse = 1'b0;
    expMode = 2'd0;
    test_reset();
    test_short_press();
    test_bounce();
    test_colon();
    test_long_max();
    test_long_day();
    test_release_coincident();
    test_reset_mid_press();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/display_mode_ctrl.md
# display_mode_ctrl

Display-mode controller for the bicycle computer. It debounces the raw `mode` button and sequences the display through four modes: DAY distance, AVS average speed, TIM trip time and MAX speed. It drives the mode indicators, the datapath select, the colon and decimal point, and issues clear requests to the distance and max-speed datapaths on a long press. It sits in the top level between the button/timing blocks and the 7-segment formatter.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable clocks required to accept a new button level (≥2).
- `LONG_PRESS_SEC`, 2: whole seconds (counted `sec_pulse`s) that make a hold a long press (1..7).
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `mode`  in  1  raw button, 1 = pressed, asynchronous to `clock`.
- `sec_pulse`  in  1  one-cycle pulse per second from timing.
- `half_sec_pulse`  in  1  one-cycle pulse per half second from timing.
- `mode_sel`  out  2  datapath select: 0 DAY, 1 AVS, 2 TIM, 3 MAX.
- `DAY`, `AVS`, `TIM`, `MAX`  out  1 each  one-hot mode indicators.
- `col`  out  1  colon segment.
- `point`  out  1  decimal point segment.
- `clr_day`  out  1  one-cycle clear request to distance.
- `clr_max`  out  1  one-cycle clear request to max-speed tracking.

## Operation
- Input path:
  - `mode` passes through a 2-FF synchronizer.
  - A debounce counter tracks the synchronized level. `btn` (debounced) takes the new level once the synchronized value has differed from `btn` for `DEBOUNCE_CYCLES` consecutive clocks.
  - Any sample equal to `btn` clears the counter.
- Button FSM states:
  - IDLE: `btn`=0. A `btn` rising edge moves to HELD and clears `hold_cnt` (3 bits).
  - HELD: each `sec_pulse` increments `hold_cnt`. When `hold_cnt` reaches `LONG_PRESS_SEC`, fire the long action and go to LONG. A `btn` falling edge fires the short action and returns to IDLE.
  - LONG: wait for the `btn` falling edge, then IDLE. The release generates no short action.
- Short action: advance the mode DAY→AVS→TIM→MAX→DAY, wrapping from MAX back to DAY.
- Long action:
  - DAY: `clr_day`=1 for one cycle.
  - MAX: `clr_max`=1 for one cycle.
  - AVS, TIM: no effect.
  - In all cases the mode does not change.
- Outputs:
  - `mode_sel` and the indicators are registered and always consistent; exactly one indicator is high.
  - `point` = 1 in DAY, AVS and MAX; 0 in TIM.
  - `col` = 0 outside TIM. On entry to TIM, `col` = 1. In TIM, each `half_sec_pulse` toggles `col`.
- Simultaneous events:
  - `sec_pulse` in the same cycle as a `btn` falling edge: the release wins. Short/long is judged on `hold_cnt` before the increment.
  - `half_sec_pulse` in the cycle TIM is entered: `col` = 1; the pulse is ignored.

## Timing
- Reset values: `mode_sel`=0, `DAY`=1, `AVS`=`TIM`=`MAX`=0, `col`=0, `point`=1, `clr_day`=`clr_max`=0.
- Reset also clears the FSM (IDLE), `btn`=0, the synchronizer, the debounce counter and `hold_cnt`.
- Reset mid-press abandons the press. A button still held after reset is seen as a new press after debounce.
- Latency, raw edge to `btn` change: 2 sync clocks + `DEBOUNCE_CYCLES` clocks.
- Latency, `btn` falling edge to new `mode_sel`/indicators/`point`/`col`: 1 clock.
- `clr_*` is asserted in the cycle after the `sec_pulse` that makes `hold_cnt` reach `LONG_PRESS_SEC`. It lasts exactly one cycle.
- `hold_cnt` never exceeds `LONG_PRESS_SEC`.
- Bounces shorter than `DEBOUNCE_CYCLES` clocks produce no event.

## Configuration
- `DISPLAY_LONG_PRESS_CLEAR_EN` defined:
  - Long-press behaviour as above.
- `DISPLAY_LONG_PRESS_CLEAR_EN` undefined:
  - No `hold_cnt` and no LONG state.
  - Every press advances the mode on release, regardless of duration.
  - `clr_day` and `clr_max` are tied to 0; the ports remain present.

## Test plan
- Reset, then 4 clean presses (each 40 clocks held, 40 released, `DEBOUNCE_CYCLES`=16) → `mode_sel` steps 1, 2, 3, 0; indicators AVS, TIM, MAX, DAY; `point` 1, 0, 1, 1.
- Press with 5 bounces of 3 clocks, then stable 40 clocks, then release → exactly one mode advance, occurring 2+16+1 clocks after the final stable release.
- In DAY, hold across 2 `sec_pulse`s → `clr_day` high exactly 1 cycle after the second pulse; on release, `mode_sel` stays 0. Repeat in MAX → `clr_max` pulses; mode stays 3.
- In TIM, apply 3 `half_sec_pulse`s → `col` goes 1, 0, 1, 0 (entry value, then toggles); after advancing to MAX, `col`=0.
- Release coincident with the second `sec_pulse` (`LONG_PRESS_SEC`=2) → short action (mode advances); no clear pulse.
- Assert `reset` while in HELD in MAX mode → all outputs take reset values immediately. After deassertion with the button still held, a release advances DAY→AVS.
